// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM access sequencer.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACT   = 3'd1,
    RD_DONE  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } mem_state_e;

  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_WAIT = 2;
  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int WAIT_W      = 8;

  // True for every state in which the controller owns the data bus.
  function automatic logic is_wr_state(input mem_state_e s);
    return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/slc3_wait_timer.sv
// Loadable down-counter with a zero flag; one instance paces both OE and WE pulses.
module slc3_wait_timer
  import slc3_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt_r;

  // Load takes priority; the count saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {WAIT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {WAIT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (cnt_r == {WAIT_W{1'b0}});

endmodule

// File: rtl/slc3_sram_ctrl.sv
// SLC-3 MAR/MDR request port to asynchronous SRAM strobe sequencer.
// Defining SLC3_BYTE_LANE_EN adds req_be and byte-lane (UB/LB) writes.
module slc3_sram_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef SLC3_BYTE_LANE_EN
  input  logic [1:0]        req_be,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Data
);

  localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(RD_WAIT - 1);
  localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WR_WAIT - 1);

  mem_state_e        state_r, next_state_s;
  logic [DATA_W-1:0] wdata_r, rsp_rdata_r;
  logic [ADDR_W-1:0] addr_r;
  logic              req_ready_r, rsp_valid_r, data_oe_r;
  logic              ce_r, oe_r, we_r, ub_r, lb_r;
  logic              accept_s, capture_s, tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [WAIT_W-1:0] tmr_load_val_s;
  logic              rd_next_s, wr_next_s, wr_en_s, ce_next_s, ub_next_s, lb_next_s;
  logic [1:0]        wr_be_s;

  slc3_wait_timer u_timer (
    .clk      (Clk),
    .rst      (Reset),
    .load     (tmr_load_s),
    .dec      (tmr_dec_s),
    .load_val (tmr_load_val_s),
    .zero     (tmr_zero_s)
  );

`ifdef SLC3_BYTE_LANE_EN
  logic [1:0] be_r;

  // Byte enables are captured with the request and steer the lanes for the whole write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      be_r <= 2'b11;
    end else if (accept_s) begin
      be_r <= req_be;
    end
  end

  assign wr_be_s = accept_s ? req_be : be_r;
`else
  assign wr_be_s = 2'b11;
`endif

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and wait-timer control.
  always_comb begin
    next_state_s   = state_r;
    accept_s       = 1'b0;
    capture_s      = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_dec_s      = 1'b0;
    tmr_load_val_s = {WAIT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (req_we) begin
            next_state_s = WR_SETUP;
          end else begin
            next_state_s   = RD_ACT;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = RD_LOAD;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RD_ACT: begin
        if (tmr_zero_s) begin
          capture_s    = 1'b1;
          next_state_s = RD_DONE;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      RD_DONE: next_state_s = IDLE;
      WR_SETUP: begin
        next_state_s   = WR_PULSE;
        tmr_load_s     = 1'b1;
        tmr_load_val_s = WR_LOAD;
      end
      WR_PULSE: begin
        if (tmr_zero_s) begin
          next_state_s = WR_HOLD;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      WR_HOLD: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Strobe levels for the upcoming state; a write with no lanes enabled keeps CE/WE high.
  always_comb begin
    rd_next_s = (next_state_s == RD_ACT);
    wr_next_s = is_wr_state(next_state_s);
    wr_en_s   = |wr_be_s;
    ce_next_s = ~(rd_next_s | (wr_next_s & wr_en_s));
    if (rd_next_s) begin
      ub_next_s = 1'b0;
      lb_next_s = 1'b0;
    end else if (wr_next_s) begin
      ub_next_s = ~wr_be_s[1];
      lb_next_s = ~wr_be_s[0];
    end else begin
      ub_next_s = 1'b1;
      lb_next_s = 1'b1;
    end
  end

  // Registered bus strobes, handshake outputs and captured data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      ce_r        <= 1'b1;
      oe_r        <= 1'b1;
      we_r        <= 1'b1;
      ub_r        <= 1'b1;
      lb_r        <= 1'b1;
      data_oe_r   <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
    end else begin
      req_ready_r <= (next_state_s == IDLE);
      rsp_valid_r <= (next_state_s == RD_DONE) || (next_state_s == WR_HOLD);
      ce_r        <= ce_next_s;
      oe_r        <= ~rd_next_s;
      we_r        <= ~((next_state_s == WR_PULSE) & wr_en_s);
      ub_r        <= ub_next_s;
      lb_r        <= lb_next_s;
      data_oe_r   <= wr_next_s;
      if (accept_s) begin
        addr_r  <= {{(ADDR_W-16){1'b0}}, req_addr};
        wdata_r <= req_wdata;
      end
      if (capture_s) begin
        rsp_rdata_r <= Data;
      end
    end
  end

  assign Data      = data_oe_r ? wdata_r : {DATA_W{1'bz}};
  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign CE        = ce_r;
  assign OE        = oe_r;
  assign WE        = we_r;
  assign UB        = ub_r;
  assign LB        = lb_r;
  assign ADDR      = addr_r;

endmodule

// File: tb/tb_slc3_sram_ctrl.sv
// Self-checking bench for slc3_sram_ctrl: directed vector table, hand sequences, random traffic.
module tb_slc3_sram_ctrl;

  localparam int RDW = 2;
  localparam int WRW = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
`ifdef SLC3_BYTE_LANE_EN
  logic [1:0]  req_be;
`endif
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  logic [15:0] mem     [0:4095];
  logic [15:0] ref_mem [0:4095];
  logic [15:0] last_rd;
  logic        init_now = 1'b0;
  logic        cur_wr   = 1'b0;
  int          bus_err  = 0;
  int          checks   = 0;
  int          passed   = 0;
  int          op_num   = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [15:0] rd;
    int          lat, ce_lo, we_lo, oe_lo, ub_lo, lb_lo, drv;
    bit          ok;
  } res_t;

  vec_t tv [8];

  slc3_sram_ctrl #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef SLC3_BYTE_LANE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .CE        (CE),
    .OE        (OE),
    .WE        (WE),
    .UB        (UB),
    .LB        (LB),
    .ADDR      (ADDR),
    .Data      (Data)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] pat(input int i);
    logic [15:0] v;
    v = (16'(i) * 16'h9E37) ^ 16'h5A5A;
    return (i == 32'h123) ? 16'hBEEF : v;
  endfunction

  function automatic logic [1:0] eff_be(input logic [1:0] be);
`ifdef SLC3_BYTE_LANE_EN
    return be;
`else
    return be | 2'b11;
`endif
  endfunction

  // Asynchronous SRAM model: combinational read, byte-lane write while CE and WE are low.
  assign Data = (!CE && !OE && WE) ? mem[ADDR[11:0]] : 16'hzzzz;

  always @(posedge Clk) begin
    if (init_now) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else if (!CE && !WE) begin
      if (!UB) mem[ADDR[11:0]][15:8] <= Data[15:8];
      if (!LB) mem[ADDR[11:0]][7:0]  <= Data[7:0];
    end
  end

  // Bus-contention monitor: OE must never be low during a write or against a foreign driver.
  always @(negedge Clk) begin
    if (!OE && (!WE || cur_wr)) bus_err <= bus_err + 1;
    else if (!OE && !CE && (Data !== mem[ADDR[11:0]])) bus_err <= bus_err + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s (op %0d): got 0x%0h, expected 0x%0h", name, op_num, act, exp);
  endtask

  // Issue one request (caller is just past a falling edge) and profile the strobes until idle.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, input bit hold, output res_t r);
    int jr;
    int n;
    r = '{default: 0};
    r.ok = 1'b1;
    jr = -1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
`ifdef SLC3_BYTE_LANE_EN
    req_be    = be;
`endif
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) begin
      r.ok = 1'b0;
      r.lat = -1;
      req_valid = 1'b0;
      return;
    end
    @(posedge Clk);
    cur_wr = we;
    for (int j = 0; j < 64; j++) begin
      @(negedge Clk);
      if (!hold) req_valid = 1'b0;
      if (j == 0 && ADDR != {4'h0, addr}) r.ok = 1'b0;
      if (jr >= 0) begin
        if (!req_ready || rsp_valid || !CE || !WE || !OE) r.ok = 1'b0;
        break;
      end
      if (req_ready) r.ok = 1'b0;
      if (!CE) r.ce_lo++;
      if (!WE) r.we_lo++;
      if (!OE) r.oe_lo++;
      if (!UB) r.ub_lo++;
      if (!LB) r.lb_lo++;
      if (OE && Data === wd) r.drv++;
      if (rsp_valid) begin
        jr = j;
        r.rd = rsp_rdata;
      end
    end
    cur_wr = 1'b0;
    r.lat = (jr < 0) ? -1 : jr + 1;
  endtask

  // Run one access and compare it against the timing/lane/data rules of the reference model.
  task automatic run(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                     input logic [1:0] be, input logic [15:0] exp_rd, input bit hold,
                     input bit chk_drv);
    res_t        r;
    logic [1:0]  eb;
    logic [15:0] m;
    op_num++;
    eb = eff_be(be);
    access(we, addr, wd, be, hold, r);
    chk("protocol", int'(r.ok), 1);
    chk("latency", r.lat, we ? WRW + 2 : RDW + 1);
    chk("ce_low_cycles", r.ce_lo, we ? ((eb != 2'b00) ? WRW + 2 : 0) : RDW);
    chk("we_low_cycles", r.we_lo, (we && eb != 2'b00) ? WRW : 0);
    chk("oe_low_cycles", r.oe_lo, we ? 0 : RDW);
    chk("ub_low_cycles", r.ub_lo, we ? (eb[1] ? WRW + 2 : 0) : RDW);
    chk("lb_low_cycles", r.lb_lo, we ? (eb[0] ? WRW + 2 : 0) : RDW);
    if (chk_drv) chk("data_drive_cycles", r.drv, WRW + 2);
    chk("rsp_rdata", int'(r.rd), int'(exp_rd));
    if (we) begin
      m = {{8{eb[1]}}, {8{eb[0]}}};
      ref_mem[addr[11:0]] = (ref_mem[addr[11:0]] & ~m) | (wd & m);
    end else begin
      last_rd = exp_rd;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          n;
    int          seen;
    logic        we;
    logic        hold;
    logic [15:0] addr, wd;
    logic [1:0]  be;

    Reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 16'h0000;
    req_wdata = 16'h0000;
`ifdef SLC3_BYTE_LANE_EN
    req_be = 2'b11;
`endif
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    last_rd = 16'h0000;
    init_now = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    init_now = 1'b0;
    chk("rst_strobes", int'({CE, OE, WE, UB, LB}), 5'b11111);
    chk("rst_addr", int'(ADDR), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rdata", int'(rsp_rdata), 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("ready_after_reset", int'(req_ready), 1);

    tv[0] = '{1'b0, 16'h0123, 16'h0000, 2'b11, 16'hBEEF};
    tv[1] = '{1'b1, 16'h0040, 16'h1234, 2'b11, 16'hBEEF};
    tv[2] = '{1'b0, 16'h0040, 16'h0000, 2'b11, 16'h1234};
    tv[3] = '{1'b1, 16'h0050, 16'h5555, 2'b11, 16'h1234};
    tv[4] = '{1'b1, 16'h0050, 16'hAB00, 2'b10, 16'h1234};
`ifdef SLC3_BYTE_LANE_EN
    tv[5] = '{1'b0, 16'h0050, 16'h0000, 2'b11, 16'hAB55};
    tv[6] = '{1'b1, 16'h0050, 16'hFFFF, 2'b00, 16'hAB55};
    tv[7] = '{1'b0, 16'h0050, 16'h0000, 2'b11, 16'hAB55};
`else
    tv[5] = '{1'b0, 16'h0050, 16'h0000, 2'b11, 16'hAB00};
    tv[6] = '{1'b1, 16'h0050, 16'hFFFF, 2'b00, 16'hAB00};
    tv[7] = '{1'b0, 16'h0050, 16'h0000, 2'b11, 16'hFFFF};
`endif
    for (int k = 0; k < 8; k++)
      run(tv[k].we, tv[k].addr, tv[k].wdata, tv[k].be, tv[k].exp_rd, 1'b0,
          tv[k].we && (tv[k].wdata != 16'h0000));

    // Back-to-back with req_valid held high throughout.
    run(1'b1, 16'h0060, 16'h0F0F, 2'b11, last_rd, 1'b1, 1'b1);
    run(1'b0, 16'h0060, 16'h0000, 2'b11, 16'h0F0F, 1'b1, 1'b0);
    run(1'b0, 16'h0123, 16'h0000, 2'b11, 16'hBEEF, 1'b0, 1'b0);

    // Reset in the middle of the write pulse.
    op_num++;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0777;
    req_wdata = 16'hC3C3;
`ifdef SLC3_BYTE_LANE_EN
    req_be    = 2'b11;
`endif
    n = 0;
    while (WE && n < 16) begin
      @(negedge Clk);
      n++;
    end
    chk("reached_wr_pulse", int'(WE), 0);
    req_valid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("abort_strobes_async", int'({CE, OE, WE, UB, LB}), 5'b11111);
    chk("abort_data_released", int'(Data !== 16'hC3C3), 1);
    seen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (rsp_valid) seen++;
    end
    Reset = 1'b0;
    chk("abort_ready", int'(req_ready), 1);
    chk("abort_addr", int'(ADDR), 0);
    chk("abort_rdata", int'(rsp_rdata), 0);
    repeat (3) begin
      @(negedge Clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    last_rd = 16'h0000;
    run(1'b0, 16'h0040, 16'h0000, 2'b11, 16'h1234, 1'b0, 1'b0);

    // Random traffic against the reference memory.
    for (int k = 0; k < 1000; k++) begin
      we   = 1'($urandom_range(0, 1));
      addr = 16'h0100 + 16'($urandom_range(0, 31));
      wd   = 16'($urandom);
      be   = 2'($urandom_range(0, 3));
      hold = (k != 999) && ($urandom_range(0, 1) == 1);
      run(we, addr, wd, be, we ? last_rd : ref_mem[addr[11:0]], hold, 1'b0);
      if (!hold && $urandom_range(0, 3) == 0) @(negedge Clk);
    end

    chk("bus_contention", bus_err, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/slc3_sram_ctrl.md
# slc3_sram_ctrl

Memory access sequencer between the SLC-3 core's MAR/MDR request port and the external asynchronous SRAM bus (test memory on the bench, board SRAM on hardware). Accepts one word request at a time over a valid/ready handshake and generates correctly ordered active-low CE/OE/WE/UB/LB strobes with programmable wait states. It drives the 16-bit bidirectional data bus only during writes and returns read data with a one-cycle completion pulse.

## Interface
Parameters:
- RD_WAIT, 2, cycles OE held low before read data is sampled (legal values: 1 or more)
- WR_WAIT, 2, cycles WE held low per write (legal values: 1 or more)

Ports:
- Clk  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  word address (from MAR)
- req_wdata  in  16  write data (from MDR)
- req_be  in  2  byte enables [1]=upper, [0]=lower (only with SLC3_BYTE_LANE_EN)
- rsp_valid  out  1  one-cycle completion pulse, read or write
- rsp_rdata  out  16  registered read data
- CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low
- ADDR  out  20  SRAM address
- Data  inout  16  SRAM data bus

## Operation
- FSM states: IDLE, RD_ACT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: req_ready=1. On req_valid, latch we/addr/wdata/be and go to RD_ACT or WR_SETUP. req_ready is 0 in every other state.
- RD_ACT: CE=0, OE=0, WE=1, UB=LB=0, and Data is tristated. A wait counter is loaded with RD_WAIT-1. When the count reaches 0, capture Data into rsp_rdata and go to RD_DONE.
- RD_DONE: CE=OE=1, rsp_valid=1, then IDLE.
- WR_SETUP: CE=0, OE=1, WE=1, Data driven with latched wdata. Lasts 1 cycle.
- WR_PULSE: WE=0 for WR_WAIT cycles.
- WR_HOLD: WE=1, CE=0, Data still driven, rsp_valid=1, then IDLE.
- ADDR = {4'b0, latched addr}. ADDR holds its last value while IDLE.
- Data is driven only in the WR_* states. OE is never low while Data is driven.
- rsp_rdata changes only on a read capture and holds across writes.
- Reset (async, effective at any point including mid-access):
  - FSM to IDLE.
  - CE=OE=WE=UB=LB=1, ADDR=0, Data tristated.
  - rsp_valid=0, rsp_rdata=0, req_ready=1 once Reset deasserts.
  - An interrupted access produces no rsp_valid.

## Timing
- Accepting edge T0 (req_valid & req_ready sampled high).
- Read: strobes low from T0 for RD_WAIT cycles; data sampled at edge T0+RD_WAIT; rsp_valid high during cycle T0+RD_WAIT..T0+RD_WAIT+1. Read latency is RD_WAIT+1 cycles.
- Write: 1 setup + WR_WAIT pulse + 1 hold cycles; rsp_valid during the hold cycle. Write latency is WR_WAIT+2 cycles.
- Next request is accepted at the earliest on the edge after rsp_valid, so there is at least 1 idle cycle between accesses (bus turnaround).
- All strobes and ADDR come from registers (glitch-free).

## Configuration
- SLC3_BYTE_LANE_EN defined:
  - req_be port exists.
  - On writes, UB=~be[1] and LB=~be[0] for the whole write.
  - be=2'b00 runs the full write timing with CE and WE held high, and still acks.
  - Reads always use both lanes.
- SLC3_BYTE_LANE_EN undefined: no req_be port; UB=LB=CE on every access (full-word only).

## Structure
- slc3_mem_pkg: state enum, default RD_WAIT/WR_WAIT constants, ADDR width constant (20), data width constant (16).
- One sub-module, slc3_wait_timer: loadable down-counter with a zero flag, instantiated once and shared by RD_ACT and WR_PULSE.

## Test plan
- Read, RD_WAIT=2, model word 0x0123 = 0xBEEF:
  - CE/OE low for exactly 2 cycles, ADDR=0x00123.
  - rsp_valid is a single pulse 3 cycles after acceptance, rsp_rdata=0xBEEF.
- Write 0x1234 to 0x0040, WR_WAIT=2:
  - Data driven from the setup cycle through the hold cycle; WE low for exactly 2 cycles.
  - A later read of 0x0040 returns 0x1234.
- Back-to-back requests with req_valid held high: req_ready low throughout each access; at least 1 idle cycle between accesses.
- Reset asserted mid-WR_PULSE:
  - All strobes high and Data high-Z immediately, without waiting for a clock.
  - No rsp_valid.
  - The next read completes normally.
- With SLC3_BYTE_LANE_EN, write 0xAB00 with be=2'b10 over 0x5555:
  - UB=0, LB=1 during the write.
  - A read returns 0xAB55.
  - be=2'b00 write: WE never low, rsp_valid still pulses.
- Bus contention check: assert that OE=0 and the controller driving Data never occur in the same cycle, across 1000 random reads and writes.
